// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 timing constants, counter widths and the sync-monitor
//   FSM encoding. Used by the VGA controller and by vga_sync_monitor.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_CNT_W  = 11;
  localparam int unsigned V_CNT_W  = 10;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

endpackage

// File: rtl/vga_sync_sampler.sv
// vga_sync_sampler
//   Stage-1 input registers for the sync monitor. Samples sync, bright and
//   RGB on each pixel strobe and flags sync edges between the last two
//   samples.
// Ports
//   clk, clear             : clock, synchronous active-high reset
//   pix_en                 : pixel strobe; registers hold when 0
//   hSync, vSync           : active-low syncs as driven to the DAC
//   bright, rgb_*          : active-video flag and pixel colour
//   bright_smp, rgb_smp    : sampled bright / {R,G,B}
//   hs_fall/hs_rise,
//   vs_fall/vs_rise        : edges between previous and current sample
module vga_sync_sampler (
  input  logic        clk,
  input  logic        clear,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  input  logic [7:0]  rgb_red,
  input  logic [7:0]  rgb_green,
  input  logic [7:0]  rgb_blue,
  output logic        bright_smp,
  output logic [23:0] rgb_smp,
  output logic        hs_fall,
  output logic        hs_rise,
  output logic        vs_fall,
  output logic        vs_rise
);

  logic hs_cur, hs_prev, vs_cur, vs_prev;

  always_ff @(posedge clk) begin
    if (clear) begin
      hs_cur     <= 1'b0;
      hs_prev    <= 1'b0;
      vs_cur     <= 1'b0;
      vs_prev    <= 1'b0;
      bright_smp <= 1'b0;
      rgb_smp    <= '0;
    end else if (pix_en) begin
      hs_prev    <= hs_cur;
      hs_cur     <= hSync;
      vs_prev    <= vs_cur;
      vs_cur     <= vSync;
      bright_smp <= bright;
      rgb_smp    <= {rgb_red, rgb_green, rgb_blue};
    end
  end

  assign hs_fall = hs_prev & ~hs_cur;
  assign hs_rise = ~hs_prev & hs_cur;
  assign vs_fall = vs_prev & ~vs_cur;
  assign vs_rise = ~vs_prev & vs_cur;

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Loopback checker for the VGA output: recovers pixel coordinates from
//   hSync/vSync, checks line/frame timing, locks after a clean frame and
//   captures one probe pixel per locked frame.
// Ports
//   clk, clear      : clock, synchronous active-high reset
//   pix_en          : pixel strobe; all state holds when 0
//   hSync, vSync    : active-low syncs
//   bright, rgb_*   : active-video flag and colour
//   locked          : a full frame with correct timing was seen
//   pixel_valid,x,y : locked and current sample inside the active window
//   frame_done      : one-clk pulse on each good vSync fall while locked
//   probe_rgb       : {R,G,B} at (PROBE_X,PROBE_Y) of the last locked frame
//   h_err, v_err,
//   blank_err       : sticky timing / blanking errors
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned PROBE_X  = 320,
  parameter int unsigned PROBE_Y  = 240
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  input  logic [7:0]  rgb_red,
  input  logic [7:0]  rgb_green,
  input  logic [7:0]  rgb_blue,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        frame_done,
  output logic [23:0] probe_rgb,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err
);

  import vga_timing_pkg::*;

  localparam int unsigned HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_LAST      = H_CNT_W'(HTOT - 1);
  localparam logic [H_CNT_W-1:0] H_SYNC_LAST = H_CNT_W'(H_SYNC - 1);
  localparam logic [H_CNT_W-1:0] H_START     = H_CNT_W'(H_SYNC + H_BP);
  localparam logic [H_CNT_W-1:0] H_END       = H_CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_LAST      = V_CNT_W'(VTOT - 1);
  localparam logic [V_CNT_W-1:0] V_SYNC_LAST = V_CNT_W'(V_SYNC - 1);
  localparam logic [V_CNT_W-1:0] V_START     = V_CNT_W'(V_SYNC + V_BP);
  localparam logic [V_CNT_W-1:0] V_END       = V_CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]         PROBE_XV    = 10'(PROBE_X);
  localparam logic [8:0]         PROBE_YV    = 9'(PROBE_Y);

  logic        bright_smp;
  logic [23:0] rgb_smp;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;

  sync_state_t         state_q, state_d;
  logic [H_CNT_W-1:0]  h_cnt, h_next;
  logic [V_CNT_W-1:0]  v_cnt, v_next;
  logic                h_fail, v_fail, in_win, valid_d;
  logic [9:0]          hx;
  logic [8:0]          vy;

  vga_sync_sampler u_sampler (
    .clk        (clk),
    .clear      (clear),
    .pix_en     (pix_en),
    .hSync      (hSync),
    .vSync      (vSync),
    .bright     (bright),
    .rgb_red    (rgb_red),
    .rgb_green  (rgb_green),
    .rgb_blue   (rgb_blue),
    .bright_smp (bright_smp),
    .rgb_smp    (rgb_smp),
    .hs_fall    (hs_fall),
    .hs_rise    (hs_rise),
    .vs_fall    (vs_fall),
    .vs_rise    (vs_rise)
  );

  // Checks compare the count held before this sample; the window uses the
  // count after it, i.e. the coordinate of the sample itself.
  always_comb begin
    h_next = hs_fall ? '0 : ((&h_cnt) ? h_cnt : h_cnt + 1'b1);
    v_next = v_cnt;
    if (vs_fall)
      v_next = '0;
    else if (hs_fall && !(&v_cnt))
      v_next = v_cnt + 1'b1;

    h_fail = (hs_fall && (h_cnt != H_LAST)) || (hs_rise && (h_cnt != H_SYNC_LAST));
    v_fail = (vs_fall && (v_cnt != V_LAST)) || (vs_rise && (v_cnt != V_SYNC_LAST));

    in_win = (h_next >= H_START) && (h_next < H_END) &&
             (v_next >= V_START) && (v_next < V_END);
    hx     = 10'(h_next - H_START);
    vy     = 9'(v_next - V_START);

    state_d = state_q;
    if (pix_en) begin
      case (state_q)
        SEEK:    if (vs_fall) state_d = ACQUIRE;
        ACQUIRE: if (h_fail || v_fail) state_d = SEEK;
                 else if (vs_fall)     state_d = LOCKED;
        LOCKED:  if (h_fail || v_fail) state_d = SEEK;
        default: state_d = SEEK;
      endcase
    end

    valid_d = (state_d == LOCKED) && in_win;
  end

  always_ff @(posedge clk) begin
    if (clear) state_q <= SEEK;
    else       state_q <= state_d;
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk) begin
    if (clear) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      probe_rgb   <= '0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      blank_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pix_en) begin
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        pixel_valid <= valid_d;
        x           <= valid_d ? hx : '0;
        y           <= valid_d ? vy : '0;
        if (state_q != SEEK) begin
          h_err <= h_err | h_fail;
          v_err <= v_err | v_fail;
        end
        if (state_q == LOCKED) begin
          blank_err  <= blank_err | (bright_smp != in_win);
          // a timing failure on the vSync edge suppresses the pulse
          frame_done <= vs_fall && !h_fail && !v_fail;
        end
        if (valid_d && (hx == PROBE_XV) && (vy == PROBE_YV))
          probe_rgb <= rgb_smp;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor
//   Directed bench for vga_sync_monitor using a reduced timing (25x13) so a
//   frame takes 325 pixel strobes. A small stream generator drives the
//   monitor; pix_en alternates 0/1 each clock.
module tb_vga_sync_monitor;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int HSTART = HS + HB;
  localparam int VSTART = VS + VB;
  localparam int PX = 5, PY = 3;
  localparam logic [23:0] PROBE_EXP = {8'(PX), 8'(PY), 8'hA5};

  logic        clk = 1'b0;
  logic        clear, pix_en, hSync, vSync, bright;
  logic [7:0]  rgb_red, rgb_green, rgb_blue;
  logic        locked, pixel_valid, frame_done, h_err, v_err, blank_err;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [23:0] probe_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  // generator state: (hc,vc) is the next sample to emit; o_* is the sample
  // the DUT outputs describe after the latest strobe
  int hc, vc, cur_len, vsync_lines;
  bit force_br;
  int p_hc, p_vc, o_hc, o_vc;
  int pv_cnt;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .PROBE_X  (PX), .PROBE_Y (PY)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .pix_en      (pix_en),
    .hSync       (hSync),
    .vSync       (vSync),
    .bright      (bright),
    .rgb_red     (rgb_red),
    .rgb_green   (rgb_green),
    .rgb_blue    (rgb_blue),
    .locked      (locked),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .frame_done  (frame_done),
    .probe_rgb   (probe_rgb),
    .h_err       (h_err),
    .v_err       (v_err),
    .blank_err   (blank_err)
  );

  function automatic bit in_win(int h, int v);
    return (h >= HSTART) && (h < HSTART + HA) && (v >= VSTART) && (v < VSTART + VA);
  endfunction

  // one pixel: idle clock, then strobe clock; returns #1 after the strobe
  task automatic emit();
    bit br;
    br        = in_win(hc, vc);
    hSync     = (hc >= HS);
    vSync     = (vc >= vsync_lines);
    bright    = br | (force_br && hc == 0);
    rgb_red   = br ? 8'(hc - HSTART) : 8'h00;
    rgb_green = br ? 8'(vc - VSTART) : 8'h00;
    rgb_blue  = br ? 8'hA5 : 8'h00;
    pix_en = 1'b0;
    @(posedge clk); #1;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    o_hc = p_hc; o_vc = p_vc;
    p_hc = hc;   p_vc = vc;
    if (pixel_valid) pv_cnt++;
    hc++;
    if (hc == cur_len) begin
      hc = 0;
      cur_len = HT;
      vc++;
      if (vc == VT) vc = 0;
    end
  endtask

  task automatic emit_until_origin();
    int k;
    k = 0;
    do begin
      emit();
      k++;
    end while (!(o_hc == 0 && o_vc == 0) && k <= 2 * FT);
  endtask

  task automatic run_until_gen(input int h, input int v);
    int k;
    k = 0;
    while (!(hc == h && vc == v) && k <= 2 * FT) begin
      emit();
      k++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; pix_en = 1'b1; hSync = 1'b0; vSync = 1'b0; bright = 1'b1;
    rgb_red = 8'hFF; rgb_green = 8'hFF; rgb_blue = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({locked, pixel_valid, x, y, frame_done, probe_rgb, h_err, v_err, blank_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lk=%b pv=%b x=%0d y=%0d fd=%b probe=%h he=%b ve=%b be=%b, expected all 0",
               locked, pixel_valid, x, y, frame_done, probe_rgb, h_err, v_err, blank_err);
    end
    clear = 1'b0; pix_en = 1'b0;
    hc = 0; vc = VT - 1; cur_len = HT; vsync_lines = VS; force_br = 1'b0;
    p_hc = -1; p_vc = -1; o_hc = -1; o_vc = -1; pv_cnt = 0;
  endtask

  task automatic test_lock();
    emit_until_origin();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_first_vs: got locked=%b expected 0", locked); end
    emit_until_origin();
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_second_vs: got locked=%b expected 1", locked); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL lock_no_fd: got frame_done=%b expected 0", frame_done); end
    n_checks++;
    if ({h_err, v_err, blank_err} !== 3'b000) begin
      n_fail++; $display("FAIL lock_errors: got %b expected 000", {h_err, v_err, blank_err});
    end
    n_checks++;
    if (probe_rgb !== 24'h0) begin n_fail++; $display("FAIL probe_before_frame: got %h expected 000000", probe_rgb); end
  endtask

  task automatic test_clean_frame();
    bit         exp_pv, exp_fd;
    logic [9:0] exp_x;
    logic [8:0] exp_y;
    pv_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      emit();
      exp_pv = in_win(o_hc, o_vc);
      exp_x  = exp_pv ? 10'(o_hc - HSTART) : 10'd0;
      exp_y  = exp_pv ? 9'(o_vc - VSTART) : 9'd0;
      exp_fd = (o_hc == 0 && o_vc == 0);
      n_checks++;
      if (pixel_valid !== exp_pv) begin
        n_fail++; $display("FAIL pixel_valid at (%0d,%0d): got %b expected %b", o_hc, o_vc, pixel_valid, exp_pv);
      end
      n_checks++;
      if (x !== exp_x) begin n_fail++; $display("FAIL x at (%0d,%0d): got %0d expected %0d", o_hc, o_vc, x, exp_x); end
      n_checks++;
      if (y !== exp_y) begin n_fail++; $display("FAIL y at (%0d,%0d): got %0d expected %0d", o_hc, o_vc, y, exp_y); end
      n_checks++;
      if (frame_done !== exp_fd) begin
        n_fail++; $display("FAIL frame_done at (%0d,%0d): got %b expected %b", o_hc, o_vc, frame_done, exp_fd);
      end
    end
    n_checks++;
    if (pv_cnt != HA * VA) begin n_fail++; $display("FAIL pixel_count: got %0d expected %0d", pv_cnt, HA * VA); end
    n_checks++;
    if (probe_rgb !== PROBE_EXP) begin n_fail++; $display("FAIL probe_rgb: got %h expected %h", probe_rgb, PROBE_EXP); end
    n_checks++;
    if ({locked, h_err, v_err, blank_err} !== 4'b1000) begin
      n_fail++; $display("FAIL clean_status: got lk/he/ve/be=%b expected 1000", {locked, h_err, v_err, blank_err});
    end
  endtask

  task automatic test_hold();
    pix_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hSync = i[0]; vSync = i[1]; bright = 1'b1;
      rgb_red = 8'hFF; rgb_green = 8'hFF; rgb_blue = 8'hFF;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({locked, pixel_valid, x, y, frame_done, probe_rgb, h_err, v_err, blank_err} !==
        {1'b1, 1'b0, 10'd0, 9'd0, 1'b0, PROBE_EXP, 3'b000}) begin
      n_fail++;
      $display("FAIL hold: got lk=%b pv=%b x=%0d y=%0d fd=%b probe=%h errs=%b expected lk=1 pv=0 x=0 y=0 fd=0 probe=%h errs=000",
               locked, pixel_valid, x, y, frame_done, probe_rgb, {h_err, v_err, blank_err}, PROBE_EXP);
    end
    emit_until_origin();
    n_checks++;
    if ({locked, frame_done, h_err, v_err, blank_err} !== 5'b11000) begin
      n_fail++; $display("FAIL after_hold: got lk/fd/he/ve/be=%b expected 11000", {locked, frame_done, h_err, v_err, blank_err});
    end
  endtask

  task automatic test_stretch();
    run_until_gen(0, 5);
    cur_len = HT + 1;
    for (int i = 0; i < HT + 2; i++) emit();
    n_checks++;
    if ({locked, h_err} !== 2'b10) begin
      n_fail++; $display("FAIL stretch_pre: got lk/he=%b expected 10", {locked, h_err});
    end
    emit();
    n_checks++;
    if ({locked, h_err, v_err} !== 3'b010) begin
      n_fail++; $display("FAIL stretch_detect: got lk/he/ve=%b expected 010", {locked, h_err, v_err});
    end
    emit_until_origin();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL stretch_acquire: got locked=%b expected 0", locked); end
    emit_until_origin();
    n_checks++;
    if ({locked, frame_done, h_err} !== 3'b101) begin
      n_fail++; $display("FAIL stretch_relock: got lk/fd/he=%b expected 101", {locked, frame_done, h_err});
    end
  endtask

  task automatic test_vsync_long();
    run_until_gen(0, 0);
    vsync_lines = VS + 1;
    emit();
    emit();
    n_checks++;
    if ({locked, frame_done} !== 2'b11) begin
      n_fail++; $display("FAIL vlong_fd: got lk/fd=%b expected 11", {locked, frame_done});
    end
    for (int i = 0; i < 3 * HT - 1; i++) emit();
    n_checks++;
    if ({locked, v_err} !== 2'b10) begin n_fail++; $display("FAIL vlong_pre: got lk/ve=%b expected 10", {locked, v_err}); end
    emit();
    vsync_lines = VS;
    n_checks++;
    if ({locked, h_err, v_err} !== 3'b011) begin
      n_fail++; $display("FAIL vlong_detect: got lk/he/ve=%b expected 011", {locked, h_err, v_err});
    end
    for (int i = 0; i < 10; i++) emit();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if ({locked, h_err, v_err, blank_err} !== 4'b0000) begin
      n_fail++; $display("FAIL clear_errors: got lk/he/ve/be=%b expected 0000", {locked, h_err, v_err, blank_err});
    end
  endtask

  task automatic test_blank();
    emit_until_origin();
    emit_until_origin();
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL blank_lock: got locked=%b expected 1", locked); end
    run_until_gen(0, VSTART + 1);
    force_br = 1'b1;
    emit();
    force_br = 1'b0;
    n_checks++;
    if (blank_err !== 1'b0) begin n_fail++; $display("FAIL blank_pre: got blank_err=%b expected 0", blank_err); end
    emit();
    n_checks++;
    if ({locked, blank_err, h_err, v_err} !== 4'b1100) begin
      n_fail++; $display("FAIL blank_detect: got lk/be/he/ve=%b expected 1100", {locked, blank_err, h_err, v_err});
    end
    emit_until_origin();
    n_checks++;
    if ({locked, frame_done} !== 2'b11) begin
      n_fail++; $display("FAIL blank_keeps_lock: got lk/fd=%b expected 11", {locked, frame_done});
    end
  endtask

  task automatic test_clear_mid();
    int k;
    k = 0;
    while (!(o_hc == HSTART + 2 && o_vc == VSTART + 2) && k <= 2 * FT) begin
      emit();
      k++;
    end
    n_checks++;
    if ({locked, pixel_valid, x, y} !== {1'b1, 1'b1, 10'd2, 9'd2}) begin
      n_fail++; $display("FAIL mid_pre: got lk=%b pv=%b x=%0d y=%0d expected lk=1 pv=1 x=2 y=2", locked, pixel_valid, x, y);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if ({locked, pixel_valid, x, y, frame_done, probe_rgb, h_err, v_err, blank_err} !== '0) begin
      n_fail++;
      $display("FAIL mid_clear: got lk=%b pv=%b x=%0d y=%0d fd=%b probe=%h he=%b ve=%b be=%b, expected all 0",
               locked, pixel_valid, x, y, frame_done, probe_rgb, h_err, v_err, blank_err);
    end
    emit_until_origin();
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_acquire: got locked=%b expected 0", locked); end
    emit_until_origin();
    n_checks++;
    if ({locked, probe_rgb} !== {1'b1, 24'h0}) begin
      n_fail++; $display("FAIL mid_relock: got locked=%b probe=%h expected 1 / 000000", locked, probe_rgb);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_clean_frame();
    test_hold();
    test_stretch();
    test_vsync_long();
    test_blank();
    test_clear_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
